// File: rtl/alu_pipe.sv
// Registered, handshaked ALU with an iterative shift-add multiplier.
// Each accepted operation produces one result, held until the consumer pops it.
module alu_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control_bus,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] outp,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  localparam logic [2:0] OpAdd = 3'b000;
  localparam logic [2:0] OpSub = 3'b001;
  localparam logic [2:0] OpAnd = 3'b010;
  localparam logic [2:0] OpOr  = 3'b011;
  localparam logic [2:0] OpXor = 3'b100;
  localparam logic [2:0] OpNot = 3'b101;
  localparam logic [2:0] OpShl = 3'b110;
  localparam logic [2:0] OpMul = 3'b111;

  localparam logic [SHW-1:0] LastStep = SHW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     outp_q, outp_d;
  logic                 c_q, c_d, z_q, z_d, n_q, n_d, v_q, v_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic                 accept;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_c, alu_v;
  logic [WIDTH:0]       sum, diff, shl;
  logic [WIDTH-1:0]     b_neg;
  logic [2*WIDTH-1:0]   acc_step;

  assign in_ready  = enable & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
  assign accept    = in_valid & in_ready;
  assign out_valid = (state_q == StDone);
  assign outp      = outp_q;
  assign flag_c    = c_q;
  assign flag_z    = z_q;
  assign flag_n    = n_q;
  assign flag_v    = v_q;

  assign sum      = {1'b0, a} + {1'b0, b};
  assign diff     = {1'b0, a} - {1'b0, b};
  assign b_neg    = ~b + WIDTH'(1);
  // Bit WIDTH of the widened shift is the last bit shifted out (0 for a zero shift).
  assign shl      = {1'b0, a} << b[SHW-1:0];
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    unique case (control_bus)
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = (a < b);
        alu_v   = (a[WIDTH-1] == b_neg[WIDTH-1]) & (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: alu_res = a & b;
      OpOr:  alu_res = a | b;
      OpXor: alu_res = a ^ b;
      OpNot: alu_res = ~a;
      OpShl: begin
        alu_res = shl[WIDTH-1:0];
        alu_c   = shl[WIDTH];
      end
      OpMul: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    outp_d   = outp_q;
    c_d      = c_q;
    z_d      = z_q;
    n_d      = n_q;
    v_d      = v_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: ;
      StMul: begin
        if (enable) begin
          acc_d    = acc_step;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + SHW'(1);
          if (cnt_q == LastStep) begin
            state_d = StDone;
            outp_d  = acc_step[WIDTH-1:0];
            c_d     = |acc_step[2*WIDTH-1:WIDTH];
            z_d     = (acc_step[WIDTH-1:0] == '0);
            n_d     = acc_step[WIDTH-1];
            v_d     = 1'b0;
          end
        end
      end
      StDone: begin
        if (enable && out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new issue overrides the pop-to-idle transition for back-to-back operation.
    if (accept) begin
      if (control_bus == OpMul) begin
        state_d  = StMul;
        mcand_d  = {{WIDTH{1'b0}}, a};
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d = StDone;
        outp_d  = alu_res;
        c_d     = alu_c;
        z_d     = (alu_res == '0);
        n_d     = alu_res[WIDTH-1];
        v_d     = alu_v;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      outp_q   <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      v_q      <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      outp_q   <= outp_d;
      c_q      <= c_d;
      z_q      <= z_d;
      n_q      <= n_d;
      v_q      <= v_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic [2:0] control_bus;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] outp;
  logic       flag_c, flag_z, flag_n, flag_v;

  int checks = 0;
  int errors = 0;

  alu_pipe #(.WIDTH(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .control_bus (control_bus),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .outp        (outp),
    .flag_c      (flag_c),
    .flag_z      (flag_z),
    .flag_n      (flag_n),
    .flag_v      (flag_v)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] flags();
    return {flag_c, flag_z, flag_n, flag_v};
  endfunction

  // Count falling edges after the accept edge until out_valid; optionally pause enable
  // for three cycles starting at falling edge pause_at.
  task automatic wait_valid(input string tag, input int pause_at, output int lat);
    lat = -1;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clock);
      if (out_valid) begin
        lat = n;
        break;
      end
      if (pause_at > 0 && n == pause_at + 1) chk({tag, "_rdy_frozen"}, in_ready, 0);
      if (pause_at > 0 && n == pause_at) enable = 1'b0;
      if (pause_at > 0 && n == pause_at + 3) enable = 1'b1;
    end
    if (lat < 0) chk({tag, "_timeout"}, 1, 0);
  endtask

  task automatic issue(input string tag, input logic [2:0] op, input logic [7:0] aa,
                       input logic [7:0] bb);
    @(negedge clock);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid    = 1'b1;
    a           = aa;
    b           = bb;
    control_bus = op;
    @(posedge clock);
    #1;
    in_valid    = 1'b0;
    a           = 8'($urandom);
    b           = 8'($urandom);
    control_bus = 3'($urandom);
  endtask

  task automatic pop(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    out_ready = 1'b0;
    @(negedge clock);
    chk({tag, "_popped"}, out_valid, 0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] aa,
                        input logic [7:0] bb, input logic [7:0] eo, input logic [3:0] ef,
                        input int elat, input int pause_at);
    int lat;
    issue(tag, op, aa, bb);
    wait_valid(tag, pause_at, lat);
    chk({tag, "_lat"}, lat, elat);
    chk({tag, "_outp"}, outp, eo);
    chk({tag, "_flags"}, flags(), ef);
    pop(tag);
  endtask

  initial begin
    int stale;
    reset       = 1'b1;
    enable      = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    a           = '0;
    b           = '0;
    control_bus = '0;
    #22;
    chk("rst_valid", out_valid, 0);
    chk("rst_outp", outp, 0);
    chk("rst_flags", flags(), 0);
    reset = 1'b0;
    #1;
    chk("rst_ready", in_ready, 1);

    // flags are {C, Z, N, V}
    run_op("add_1_2",   3'b000, 8'h01, 8'h02, 8'h03, 4'b0000, 1, 0);
    run_op("add_ff_1",  3'b000, 8'hFF, 8'h01, 8'h00, 4'b1100, 1, 0);
    run_op("add_v",     3'b000, 8'h7F, 8'h01, 8'h80, 4'b0011, 1, 0);
    run_op("sub_80_1",  3'b001, 8'h80, 8'h01, 8'h7F, 4'b0001, 1, 0);
    run_op("sub_1_2",   3'b001, 8'h01, 8'h02, 8'hFF, 4'b1010, 1, 0);
    run_op("and",       3'b010, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1, 0);
    run_op("or",        3'b011, 8'hF0, 8'h0F, 8'hFF, 4'b0010, 1, 0);
    run_op("xor",       3'b100, 8'hAA, 8'hAA, 8'h00, 4'b0100, 1, 0);
    run_op("not",       3'b101, 8'h0F, 8'h55, 8'hF0, 4'b0010, 1, 0);
    run_op("shl_1",     3'b110, 8'h81, 8'h01, 8'h02, 4'b1000, 1, 0);
    run_op("shl_0",     3'b110, 8'h81, 8'h08, 8'h81, 4'b0010, 1, 0);
    run_op("shl_3",     3'b110, 8'h23, 8'h03, 8'h18, 4'b1000, 1, 0);
    run_op("mul_0f_11", 3'b111, 8'h0F, 8'h11, 8'hFF, 4'b0010, 9, 0);
    run_op("mul_10_10", 3'b111, 8'h10, 8'h10, 8'h00, 4'b1100, 9, 0);
    run_op("mul_pause", 3'b111, 8'h0F, 8'h11, 8'hFF, 4'b0010, 12, 3);

    // Backpressure, frozen pop, then back-to-back issue on the pop edge.
    begin
      int lat;
      issue("bp", 3'b000, 8'h05, 8'h03);
      wait_valid("bp", 0, lat);
      for (int i = 0; i < 5; i++) begin
        @(negedge clock);
        chk("bp_valid", out_valid, 1);
        chk("bp_outp", outp, 8'h08);
        chk("bp_flags", flags(), 4'b0000);
        chk("bp_in_ready", in_ready, 0);
      end
      enable    = 1'b0;
      out_ready = 1'b1;
      @(negedge clock);
      chk("frozen_pop_valid", out_valid, 1);
      enable      = 1'b1;
      in_valid    = 1'b1;
      a           = 8'h10;
      b           = 8'h20;
      control_bus = 3'b000;
      #1;
      chk("b2b_in_ready", in_ready, 1);
      @(posedge clock);
      #1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      @(negedge clock);
      chk("b2b_valid", out_valid, 1);
      chk("b2b_outp", outp, 8'h30);
      pop("b2b");
    end

    // Reset during cycle 4 of a multiply.
    issue("mul_rst", 3'b111, 8'h0F, 8'h11);
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("mul_rst_valid", out_valid, 0);
    chk("mul_rst_outp", outp, 0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mul_rst_ready", in_ready, 1);
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock);
      if (out_valid) stale = 1;
    end
    chk("mul_rst_stale", stale, 0);

    run_op("post_rst", 3'b000, 8'h40, 8'h40, 8'h80, 4'b0011, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
